// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligns scalar loads/stores onto 64-bit words and splits accesses that cross a doubleword.
// Latency: accept to o_rsp_valid is 3 cycles, or 4 cycles when the access is split.
// Backpressure: o_req_ready only in IDLE; no response backpressure, so the consumer must take o_rsp_valid.
module load_store_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC0 = 3'd1;
    localparam logic [2:0] ST_ACC1 = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [2:0]              off;
    logic [3:0]              nbytes;
    logic                    split;
    logic [2*DATA_BYTES-1:0] be16;
    logic [2*DATA_WIDTH-1:0] wd128;
    logic [ADDR_WIDTH-1:0]   dw_addr;
    logic [2*DATA_WIDTH-1:0] rd128;
    logic [DATA_WIDTH-1:0]   load_dw;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Access geometry derived from the registered request.
    always_comb begin
        off     = addr_q[2:0];
        nbytes  = 4'd1 << size_q;
        split   = ({2'b00, off} + {1'b0, nbytes}) > 5'd8;
        be16    = ((16'd1 << nbytes) - 16'd1) << off;
        wd128   = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};
        dw_addr = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    end

    // Load extraction: the current read word is the upper half of a split, otherwise the only half.
    always_comb begin
        rd128    = split ? {i_mem_rdata, lo_q} : {{DATA_WIDTH{1'b0}}, i_mem_rdata};
        load_dw  = DATA_WIDTH'(rd128 >> {off, 3'b000});
        load_ext = load_dw;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'd0, load_dw[7:0]}  : {{56{load_dw[7]}},  load_dw[7:0]};
            2'd1:    load_ext = uns_q ? {48'd0, load_dw[15:0]} : {{48{load_dw[15]}}, load_dw[15:0]};
            2'd2:    load_ext = uns_q ? {32'd0, load_dw[31:0]} : {{32{load_dw[31]}}, load_dw[31:0]};
            default: load_ext = load_dw;
        endcase
    end

    // Sequencer: request capture, first/second access, data capture, one-cycle response.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    state_d = ST_ACC0;
                end
            end
            ST_ACC0: state_d = split ? ST_ACC1 : ST_CAP;
            ST_ACC1: begin
                // Read data for the ACC0 word arrives during ACC1.
                lo_d    = i_mem_rdata;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                rdata_d = we_q ? {DATA_WIDTH{1'b0}} : load_ext;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory and response outputs; forced quiet while rst is high so an
    // interrupted split never writes its upper half.
    always_comb begin
        o_req_ready = rst || (state_q == ST_IDLE);
        o_rsp_valid = !rst && (state_q == ST_RESP);
        o_rsp_rdata = rdata_q;
        o_mem_addr  = '0;
        o_mem_wen   = '0;
        o_mem_wdata = '0;
        if (!rst && state_q == ST_ACC0) begin
            o_mem_addr  = dw_addr;
            o_mem_wen   = we_q ? be16[DATA_BYTES-1:0] : '0;
            o_mem_wdata = wd128[DATA_WIDTH-1:0];
        end else if (!rst && state_q == ST_ACC1) begin
            o_mem_addr  = dw_addr + ADDR_WIDTH'(8);
            o_mem_wen   = we_q ? be16[2*DATA_BYTES-1:DATA_BYTES] : '0;
            o_mem_wdata = wd128[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-enabled data memory model.
// Memory read data is registered: valid the cycle after the address.
// Inputs driven and outputs sampled on the falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'd0;
    logic        i_req_unsigned = 1'b0;
    logic [63:0] i_req_addr = 64'd0;
    logic [63:0] i_req_wdata = 64'd0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_rdata;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wen;
    logic [63:0] i_mem_rdata = 64'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wen      (o_mem_wen),
        .i_mem_rdata    (i_mem_rdata)
    );

    // 64 doublewords, aliased on addr[8:3]; backdoor port preloads words.
    logic [63:0] mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [63:0] bd_dat = 64'd0;

    always @(posedge clk) begin
        i_mem_rdata <= mem[o_mem_addr[8:3]];
        if (bd_we) begin
            mem[bd_idx] <= bd_dat;
        end else begin
            for (int b = 0; b < 8; b++)
                if (o_mem_wen[b]) mem[o_mem_addr[8:3]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [5:0] idx, input logic [63:0] dat);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_dat = dat;
        @(negedge clk);
        bd_we  = 1'b0;
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata);
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
    endtask

    // Per-cycle memory-port snapshot of the last request (index 1 = ACC0).
    logic [63:0] cy_addr [1:8];
    logic [7:0]  cy_wen  [1:8];
    logic [63:0] cy_wd   [1:8];

    // Issue one request from an idle DUT; report latency and response data.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int exp_lat, input logic [63:0] exp_rd);
        int          lat;
        int          pulses;
        logic [63:0] rd;
        lat = 0;
        pulses = 0;
        rd = 64'hDEAD;
        check({tag, "_ready"}, {63'd0, o_req_ready}, 64'd1);
        set_req(we, size, uns, addr, wdata);
        i_req_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            i_req_valid = 1'b0;
            cy_addr[c] = o_mem_addr;
            cy_wen[c]  = o_mem_wen;
            cy_wd[c]   = o_mem_wdata;
            if (o_rsp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c;
                    rd  = o_rsp_rdata;
                end
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, o_req_ready}, 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {63'd0, o_req_ready}, 64'd1);
            check("idle_wen",   {56'd0, o_mem_wen}, 64'd0);
            check("idle_addr",  o_mem_addr, 64'd0);
            check("idle_rspv",  {63'd0, o_rsp_valid}, 64'd0);
        end
        check("idle_rdata", o_rsp_rdata, 64'd0);

        // Preload memory.
        bd_write(6'd8,  64'd0);
        bd_write(6'd32, 64'h8877665544332211);
        bd_write(6'd33, 64'hAAAAAAAAAAAAAAAA);
        bd_write(6'd34, 64'hBBBBBBBBBBBBBBBB);
        bd_write(6'd1,  64'h1111111111111111);
        bd_write(6'd2,  64'h1111111111111111);

        // Console byte store.
        do_req("sb40", 1'b1, 2'd0, 1'b0, 64'h40, 64'h41, 3, 64'd0);
        check("sb40_acc0_addr", cy_addr[1], 64'h40);
        check("sb40_acc0_wen",  {56'd0, cy_wen[1]}, 64'h01);
        check("sb40_acc0_wd",   {56'd0, cy_wd[1][7:0]}, 64'h41);
        check("sb40_cap_wen",   {56'd0, cy_wen[2]}, 64'd0);
        check("sb40_mem",       mem[8], 64'h41);
        if (mem[8][7:0] == 8'h41) $display("console: %c", mem[8][7:0]);

        // Halfword loads at the top lanes of a word.
        do_req("lh106",  1'b0, 2'd1, 1'b0, 64'h106, 64'd0, 3, 64'hFFFFFFFFFFFF8877);
        check("lh106_acc0_addr", cy_addr[1], 64'h100);
        check("lh106_acc0_wen",  {56'd0, cy_wen[1]}, 64'd0);
        do_req("lhu106", 1'b0, 2'd1, 1'b1, 64'h106, 64'd0, 3, 64'h0000000000008877);
        do_req("lbu101", 1'b0, 2'd0, 1'b1, 64'h101, 64'd0, 3, 64'h22);

        // Split doubleword store at offset 5, then read it back.
        do_req("sd10d", 1'b1, 2'd3, 1'b0, 64'h10D, 64'h0102030405060708, 4, 64'd0);
        check("sd10d_acc0_addr", cy_addr[1], 64'h108);
        check("sd10d_acc0_wen",  {56'd0, cy_wen[1]}, 64'hE0);
        check("sd10d_acc0_wd",   cy_wd[1], 64'h0607080000000000);
        check("sd10d_acc1_addr", cy_addr[2], 64'h110);
        check("sd10d_acc1_wen",  {56'd0, cy_wen[2]}, 64'h1F);
        check("sd10d_acc1_wd",   cy_wd[2], 64'h0000000102030405);
        check("sd10d_cap_addr",  cy_addr[3], 64'd0);
        check("sd10d_mem_lo",    mem[33], 64'h060708AAAAAAAAAA);
        check("sd10d_mem_hi",    mem[34], 64'hBBBBBB0102030405);
        do_req("ld10d", 1'b0, 2'd3, 1'b0, 64'h10D, 64'd0, 4, 64'h0102030405060708);

        // Split signed word load spanning 0x10E..0x111.
        do_req("lw10e", 1'b0, 2'd2, 1'b0, 64'h10E, 64'd0, 4, 64'h0000000004050607);

        // Signed word load, with a second request held off until ready returns.
        bd_write(6'd32, 64'h8000000000000000);
        set_req(1'b0, 2'd2, 1'b0, 64'h104, 64'd0);
        i_req_valid = 1'b1;
        @(negedge clk);
        set_req(1'b0, 2'd0, 1'b1, 64'h107, 64'd0);
        check("hold_acc0_ready", {63'd0, o_req_ready}, 64'd0);
        @(negedge clk);
        check("hold_cap_ready",  {63'd0, o_req_ready}, 64'd0);
        @(negedge clk);
        check("hold_resp_ready", {63'd0, o_req_ready}, 64'd0);
        check("lw104_rspv",      {63'd0, o_rsp_valid}, 64'd1);
        check("lw104_rdata",     o_rsp_rdata, 64'hFFFFFFFF80000000);
        @(negedge clk);
        check("hold_idle_ready", {63'd0, o_req_ready}, 64'd1);
        @(negedge clk);
        i_req_valid = 1'b0;
        check("lbu107_acc0_addr", o_mem_addr, 64'h100);
        check("lbu107_rdata_held", o_rsp_rdata, 64'hFFFFFFFF80000000);
        @(negedge clk);
        @(negedge clk);
        check("lbu107_rspv",  {63'd0, o_rsp_valid}, 64'd1);
        check("lbu107_rdata", o_rsp_rdata, 64'h80);
        @(negedge clk);

        // Split store whose second doubleword wraps to address 0.
        do_req("swwrap", 1'b1, 2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFD, 64'h11223344, 4, 64'd0);
        check("swwrap_acc0_addr", cy_addr[1], 64'hFFFFFFFFFFFFFFF8);
        check("swwrap_acc0_wd",   cy_wd[1], 64'h2233440000000000);
        check("swwrap_acc1_addr", cy_addr[2], 64'd0);
        check("swwrap_acc1_wen",  {56'd0, cy_wen[2]}, 64'h01);
        check("swwrap_acc1_wd",   cy_wd[2], 64'h11);

        // Reset during the upper half of a split store.
        set_req(1'b1, 2'd2, 1'b0, 64'h0E, 64'hDDCCBBAA);
        i_req_valid = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        check("rstsplit_acc0_wen", {56'd0, o_mem_wen}, 64'hC0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstsplit_ready", {63'd0, o_req_ready}, 64'd1);
        check("rstsplit_wen",   {56'd0, o_mem_wen}, 64'd0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                if (o_rsp_valid) pulses++;
                @(negedge clk);
            end
            check("rstsplit_no_rsp", 64'(pulses), 64'd0);
        end
        check("rstsplit_mem_lo", mem[1], 64'hBBAA111111111111);
        check("rstsplit_mem_hi", mem[2], 64'h1111111111111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
